psum_ofifo: RTL and testbench
=============================

PSUM_OFIFO -- requirements
Module: psum_ofifo

Interface
REQ-001 Parameter psum_bw, default 16: width of one column partial sum.
REQ-002 Parameter col, default 8: number of columns, one lane per mac_array column.
REQ-003 Parameter depth, default 8: entries per column lane; SHALL be a power of two ≥ 2.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 in  input  psum_bw*col: column psums from the array's out_s; lane c is bits [psum_bw*(c+1)-1 : psum_bw*c].
REQ-007 wr  input  col: per-lane write strobe, driven by the array's valid vector.
REQ-008 rd  input  1: pop one aligned row (all lanes) when o_valid=1.
REQ-009 out  output  psum_bw*col: head entry of every lane, lane c in the same bit slice as in.
REQ-010 o_valid  output  1: every lane holds ≥1 entry.
REQ-011 o_full  output  1: at least one lane holds depth entries.
REQ-012 o_ready  output  1: no lane full; equals ~o_full.
REQ-013 o_overflow  output  1: sticky flag, a write hit a full lane.

Function
REQ-014 Each lane SHALL be an independent circular FIFO with write pointer, read pointer and wrap bit (log2(depth)+1 bits per pointer).
REQ-015 Lane c SHALL accept in lane c on a cycle with wr[c]=1 and lane c not full at that edge; the entry becomes visible the next cycle (no bypass).
REQ-016 A write to a full lane SHALL be dropped, leave the lane unchanged, and set o_overflow=1 on the next cycle.
REQ-017 Lanes SHALL fill independently; skewed column arrivals (lane c written k cycles after lane 0) SHALL be realigned by row index.
REQ-018 o_valid SHALL be the registered AND of all lane non-empty flags, reflecting pointer state after the current edge.
REQ-019 out SHALL be first-word-fall-through: when o_valid=1, out equals the oldest entry of every lane combinationally from storage; when o_valid=0, out SHALL be all zeros.
REQ-020 rd=1 with o_valid=1 SHALL advance every lane's read pointer by one on that edge; rd=1 with o_valid=0 SHALL be ignored (no pointer change, no error).
REQ-021 Simultaneous rd (accepted) and wr[c] on lane c SHALL both take effect; occupancy is unchanged. When the lane is full, only the read takes effect (full is evaluated before the edge).
REQ-022 Simultaneous rd and wr on an empty lane: the read is ignored per REQ-020, the write is accepted.
REQ-023 Pointers SHALL wrap modulo depth; full = low bits equal with the wrap bit different; empty = pointers identical.
REQ-024 o_full and o_ready SHALL be combinational from current pointers; o_full=1 exactly when any lane occupancy equals depth.
REQ-025 o_overflow SHALL remain 1 until reset.

Reset
REQ-026 On reset=1 at a rising edge, all pointers SHALL clear to 0; o_valid=0, o_full=0, o_ready=1, o_overflow=0, out=0 from the next cycle.
REQ-027 Reset SHALL take priority over simultaneous wr/rd; in-flight entries SHALL be discarded; storage contents need not be cleared.
REQ-028 Reset asserted mid-fill SHALL leave all lanes empty; the first write after deassertion lands at entry 0.

Verification
REQ-029 Reset, then idle -> o_valid=0, o_ready=1, o_full=0, o_overflow=0, out=0.
REQ-030 Skewed fill: wr[c] asserted at cycle 2+c with lane data 16'h0100+c (col=8) -> o_valid rises only after the lane-7 write; out = {16'h0107,...,16'h0100}.
REQ-031 Write 8 rows to all lanes (depth=8) -> o_full=1, o_ready=0; a 9th write -> dropped and o_overflow=1; pop 8 with rd -> values in order 0..7, then o_valid=0.
REQ-032 Full lanes with simultaneous rd and wr -> read accepted, write dropped, o_overflow=1, occupancy drops to 7.
REQ-033 Half-full lanes with continuous rd+wr for 20 cycles -> occupancy constant at 4, pointers wrap, data order preserved.
REQ-034 rd=1 with o_valid=0, and reset asserted with 3 rows stored -> no pointer change on the rd; after reset o_valid=0 and a new row reads back first.

Source files
------------

// File: rtl/psum_ofifo.sv
// Per-column output FIFO that realigns skewed mac_array column psums by row.
// Rows pop as one aligned word; out is first-word-fall-through.
module psum_ofifo #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_overflow
);

  localparam int AW = $clog2(depth);

  logic [psum_bw-1:0] mem_q [col][depth];
  logic [AW:0]        wp_q  [col];
  logic [AW:0]        rp_q  [col];
  logic [AW:0]        wp_d  [col];
  logic [AW:0]        rp_d  [col];
  logic [col-1:0]     full;
  logic [col-1:0]     push;
  logic [col-1:0]     ne_d;
  logic               pop;
  logic               valid_q;
  logic               valid_d;
  logic               ovf_q;
  logic               ovf_d;

  // full/empty are judged on pre-edge pointers; a full lane drops its write
  always_comb begin
    pop = rd & valid_q;
    for (int c = 0; c < col; c++) begin
      full[c] = (wp_q[c][AW] != rp_q[c][AW]) &&
                (wp_q[c][AW-1:0] == rp_q[c][AW-1:0]);
      push[c] = wr[c] & ~full[c];
      wp_d[c] = wp_q[c] + {{AW{1'b0}}, push[c]};
      rp_d[c] = rp_q[c] + {{AW{1'b0}}, pop};
      ne_d[c] = (wp_d[c] != rp_d[c]);
    end
    valid_d = &ne_d;
    ovf_d   = ovf_q | (|(wr & full));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < col; c++) begin
        wp_q[c] <= '0;
        rp_q[c] <= '0;
      end
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      for (int c = 0; c < col; c++) begin
        wp_q[c] <= wp_d[c];
        rp_q[c] <= rp_d[c];
      end
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++) begin
      if (push[c] && !reset)
        mem_q[c][wp_q[c][AW-1:0]] <= in[c*psum_bw +: psum_bw];
    end
  end

  always_comb begin
    out = '0;
    for (int c = 0; c < col; c++) begin
      if (valid_q)
        out[c*psum_bw +: psum_bw] = mem_q[c][rp_q[c][AW-1:0]];
    end
  end

  assign o_valid    = valid_q;
  assign o_full     = |full;
  assign o_ready    = ~(|full);
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_psum_ofifo.sv
// Scoreboard bench for psum_ofifo: stimulus queues expected rows,
// a negedge monitor pops and compares on every accepted read.
module tb_psum_ofifo;

  localparam int PW = 16;
  localparam int NC = 8;
  localparam int DP = 8;
  localparam int W  = PW * NC;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  din;
  logic [NC-1:0] wr;
  logic          rd;
  logic [W-1:0]  dout;
  logic          o_valid, o_full, o_ready, o_overflow;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] sb [$];

  psum_ofifo #(.psum_bw(PW), .col(NC), .depth(DP)) dut (
    .clk(clk), .reset(reset), .in(din), .wr(wr), .rd(rd),
    .out(dout), .o_valid(o_valid), .o_full(o_full),
    .o_ready(o_ready), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] row(int base);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < NC; c++) r[c*PW +: PW] = 16'(base + c);
    return r;
  endfunction

  task automatic chk(string n, logic [W-1:0] a, logic [W-1:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr = '0; rd = 1'b0;
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic put_row(int base);
    din = row(base); wr = '1;
    sb.push_back(row(base));
    tick();
    wr = '0;
  endtask

  task automatic drain(int n);
    rd = 1'b1;
    repeat (n) tick();
    rd = 1'b0;
  endtask

  // monitor: a read is accepted at the coming edge when rd && o_valid
  always @(negedge clk) begin
    if (!reset && rd && o_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got %0h expected none", dout);
      end else begin
        logic [W-1:0] e;
        e = sb.pop_front();
        if (dout !== e) begin
          fails++;
          $display("FAIL pop_data: got %0h expected %0h", dout, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; din = '0; wr = '0; rd = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_valid", W'(o_valid), W'(0));
    chk("rst_ready", W'(o_ready), W'(1));
    chk("rst_full", W'(o_full), W'(0));
    chk("rst_ovf", W'(o_overflow), W'(0));
    chk("rst_out", dout, '0);

    // skewed column arrival
    din = row(16'h0100);
    for (int c = 0; c < NC; c++) begin
      wr = NC'(1) << c;
      if (c == NC - 1) sb.push_back(row(16'h0100));
      tick();
      if (c < NC - 1) chk("skew_novalid", W'(o_valid), W'(0));
    end
    wr = '0;
    chk("skew_valid", W'(o_valid), W'(1));
    chk("skew_out", dout, row(16'h0100));
    drain(1);
    chk("skew_empty", W'(o_valid), W'(0));

    // fill to full, overflow, drain in order
    for (int r = 0; r < DP; r++) put_row(16'h1000 + r * 16);
    chk("full_full", W'(o_full), W'(1));
    chk("full_ready", W'(o_ready), W'(0));
    chk("full_noovf", W'(o_overflow), W'(0));
    din = row(16'hDEA0); wr = '1;
    tick();
    wr = '0;
    chk("ovf_set", W'(o_overflow), W'(1));
    chk("ovf_full", W'(o_full), W'(1));
    drain(DP);
    chk("drain_empty", W'(o_valid), W'(0));
    chk("drain_notfull", W'(o_full), W'(0));
    chk("ovf_sticky", W'(o_overflow), W'(1));

    // full with simultaneous rd+wr: read only
    do_reset();
    tick();
    chk("rst_ovf_clr", W'(o_overflow), W'(0));
    for (int r = 0; r < DP; r++) put_row(16'h2000 + r * 16);
    din = row(16'hBEE0); wr = '1; rd = 1'b1;
    tick();
    wr = '0; rd = 1'b0;
    chk("rdwr_ovf", W'(o_overflow), W'(1));
    chk("rdwr_notfull", W'(o_full), W'(0));
    drain(DP - 1);
    chk("rdwr_empty", W'(o_valid), W'(0));

    // half full, continuous rd+wr, pointers wrap
    do_reset();
    for (int r = 0; r < 4; r++) put_row(16'h3000 + r * 16);
    rd = 1'b1; wr = '1;
    for (int k = 0; k < 20; k++) begin
      din = row(16'h4000 + k * 16);
      sb.push_back(row(16'h4000 + k * 16));
      tick();
      if (k % 5 == 0) begin
        chk("stream_valid", W'(o_valid), W'(1));
        chk("stream_notfull", W'(o_full), W'(0));
      end
    end
    wr = '0;
    repeat (4) tick();
    rd = 1'b0;
    chk("stream_empty", W'(o_valid), W'(0));

    // rd while empty is ignored
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("rd_empty_valid", W'(o_valid), W'(0));
    din = row(16'h5000); wr = '1;
    tick();
    wr = '0;
    chk("rd_empty_head", dout, row(16'h5000));
    din = row(16'h5010); wr = '1;
    tick();
    din = row(16'h5020);
    tick();
    // reset with 3 rows stored and a write in flight
    reset = 1'b1; din = row(16'h5030);
    tick();
    reset = 1'b0; wr = '0;
    sb.delete();
    chk("rst3_valid", W'(o_valid), W'(0));
    chk("rst3_out", dout, '0);
    chk("rst3_ready", W'(o_ready), W'(1));
    put_row(16'h6000);
    chk("after_rst_head", dout, row(16'h6000));
    drain(1);
    chk("after_rst_empty", W'(o_valid), W'(0));
    chk("sb_drained", W'(sb.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
